// File: rtl/serial_add_ctrl_if.sv
// Handshake and data bundle for the bit-serial adder sequencer.
// The requester side (master) drives start/A/B/Cin and receives the result.
// The adder side (slave) owns busy/done/Sum/Cout.
// Optional feature macro: SERIAL_ADD_OVF_EN adds the signed-overflow flag V.
interface serial_add_ctrl_if #(
  parameter int N = 8
);
  logic         start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         Cin;
  logic         busy;
  logic         done;
  logic [N-1:0] Sum;
  logic         Cout;
`ifdef SERIAL_ADD_OVF_EN
  logic         V;

  modport master (output start, A, B, Cin, input busy, done, Sum, Cout, V);
  modport slave  (input start, A, B, Cin, output busy, done, Sum, Cout, V);
`else
  modport master (output start, A, B, Cin, input busy, done, Sum, Cout);
  modport slave  (input start, A, B, Cin, output busy, done, Sum, Cout);
`endif
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one full-adder cell reused N times, LSB first.
// Operands are captured on an accepted start, one bit is processed per clock,
// and Sum/Cout are loaded together on the last bit, followed by a one-cycle
// done pulse. A start presented in the done cycle begins the next add at once.
// Optional feature macro: SERIAL_ADD_OVF_EN adds V, the two's-complement
// overflow flag (carry into MSB xor carry out of MSB), held with Sum.
module serial_add_ctrl #(
  parameter int N = 8
) (
  input  logic              clk,
  input  logic              reset,
  serial_add_ctrl_if.slave  bus
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // One-bit full adder, split into its sum and carry halves.
  function automatic logic fa_sum(input logic a, input logic b, input logic c);
    return a ^ b ^ c;
  endfunction

  function automatic logic fa_carry(input logic a, input logic b, input logic c);
    return (a & b) | (c & (a ^ b));
  endfunction

  state_t         state_q, state_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic [N-2:0]   res_q, res_d;
  logic [N-1:0]   sum_q, sum_d;
  logic           c_q, c_d;
  logic           cout_q, cout_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [CW-1:0]  cnt_q, cnt_d;
`ifdef SERIAL_ADD_OVF_EN
  logic           v_q, v_d;
`endif

  logic           bit_sum_s;
  logic           bit_carry_s;
  logic           last_bit_s;
  logic [N-1:0]   shifted_s;

  assign bit_sum_s   = fa_sum(a_q[0], b_q[0], c_q);
  assign bit_carry_s = fa_carry(a_q[0], b_q[0], c_q);
  assign last_bit_s  = (cnt_q == CW'(N - 1));
  // New bit enters at the top; the low bits of this word are the finished result
  // on the last step, so the result register only needs to keep N-1 bits.
  assign shifted_s   = {bit_sum_s, res_q};

  // Next-state, datapath and output-flag decode for the sequencer.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    c_d     = c_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
`ifdef SERIAL_ADD_OVF_EN
    v_d     = v_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          a_d     = bus.A;
          b_d     = bus.B;
          c_d     = bus.Cin;
          res_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        a_d   = {1'b0, a_q[N-1:1]};
        b_d   = {1'b0, b_q[N-1:1]};
        c_d   = bit_carry_s;
        res_d = shifted_s[N-1:1];
        if (last_bit_s) begin
          sum_d   = shifted_s;
          cout_d  = bit_carry_s;
`ifdef SERIAL_ADD_OVF_EN
          // c_q is the carry into the MSB on this step.
          v_d     = c_q ^ bit_carry_s;
`endif
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any add in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      v_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SERIAL_ADD_OVF_EN
      v_q     <= v_d;
`endif
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.Sum  = sum_q;
  assign bus.Cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign bus.V    = v_q;
`endif

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Sequencer that time-shares a single one-bit full-adder cell to add two N-bit operands bit-serially, LSB first, one bit per clock.
- Owns the operand shift registers, the carry flip-flop, the bit counter and a start/busy/done handshake.
- Provides an area-minimal adder for datapaths that can tolerate N+1 cycles of latency.

Parameters:
- N, 8, operand/result width in bits (N >= 2).

Ports:
- clk    input   1  system clock, all state updates on rising edge
- reset  input   1  synchronous, active-high reset
- start  input   1  request; sampled only in IDLE or DONE
- A      input   N  operand A, captured on accepted start
- B      input   N  operand B, captured on accepted start
- Cin    input   1  carry-in, captured on accepted start
- busy   output  1  high while an addition is in progress
- done   output  1  one-cycle pulse when Sum/Cout are updated
- Sum    output  N  result register, held until the next completion
- Cout   output  1  final carry-out, held with Sum

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset).
- Reset values:
  - state=IDLE; busy=0; done=0; Sum=0; Cout=0.
  - Internal shift registers, carry FF and counter are all cleared to 0.
- States:
  - IDLE: busy=0, done=0. On start=1, capture A, B and Cin (into the carry FF), set count=0 and go to RUN.
  - RUN: busy=1. Each edge:
    - s = a_sr[0] ^ b_sr[0] ^ c
    - c <= (a_sr[0] & b_sr[0]) | (c & (a_sr[0] ^ b_sr[0]))
    - a_sr and b_sr shift right by 1.
    - s enters the MSB of the result shift register, which also shifts right.
    - count increments.
    - On the edge where count==N-1, load Sum from the result shift register (including the current s) and Cout from the new carry, then go to DONE.
  - DONE: done=1 and busy=0 for exactly this cycle.
    - start=1 here: capture new operands and go to RUN (back-to-back operation).
    - Otherwise go to IDLE.
- Latency:
  - start is sampled at edge 0; busy=1 after edge 0; bits are processed at edges 1..N.
  - Sum, Cout and done are valid after edge N.
  - Throughput is one add per N+1 cycles.
- start in RUN is ignored. A, B and Cin are not re-sampled mid-operation; input changes during RUN have no effect.
- Sum and Cout change only at completion; intermediate bits are never visible on Sum.
- Arithmetic: unsigned modulo 2^N with carry-out. Cout = bit N of A+B+Cin.
- Reset asserted in any state, including mid-RUN:
  - Next state is IDLE; all outputs return to reset values.
  - No done pulse; the partial result is discarded.
- Simultaneous reset and start: reset wins; start is not accepted.
- Counter width is clog2(N). The counter never exceeds N-1.

Optional Feature:
- Macro SERIAL_ADD_OVF_EN.
- When defined:
  - Adds output port V (1 bit) = two's-complement signed overflow, computed as the carry into the MSB XOR the carry out of the MSB.
  - V is captured during the final RUN cycle, loaded alongside Sum/Cout, and held.
  - V resets to 0 and clears on reset.
- When undefined: port V and its logic are absent; all other behaviour is identical.

Test Plan:
- N=8; reset for 2 cycles, then start with A=0x3C, B=0x0F, Cin=0 -> done pulses exactly once 8 edges after the accept edge (edge 8); Sum=0x4B, Cout=0; busy high during edges 1..8 and low in the done cycle.
- A=0xFF, B=0x01, Cin=0 -> Sum=0x00, Cout=1. Then A=0xFF, B=0xFF, Cin=1 -> Sum=0xFF, Cout=1.
- Accept A=0x01, B=0x01, Cin=0. At edge 3 assert start with A=0xAA, B=0x55 -> that start is ignored; result Sum=0x02. Hold start=1 in the DONE cycle with A=0x10, B=0x20 -> new add begins immediately, giving Sum=0x30 N+1 cycles later.
- Start A=0xF0, B=0x0F. Assert reset at edge 4 for 1 cycle -> no done pulse; busy=0, Sum=0x00, Cout=0. A following add of A=0x05, B=0x03 yields Sum=0x08.
- With SERIAL_ADD_OVF_EN: A=0x7F, B=0x01 -> Sum=0x80, Cout=0, V=1. A=0x80, B=0x80 -> Sum=0x00, Cout=1, V=1. A=0xFF, B=0x01 -> V=0.
- Random regression: 1000 random A, B, Cin values compared against the reference {Cout,Sum}=A+B+Cin, checking that done fires exactly once per accepted start.
